gb_int_ctrl: RTL and testbench

Game Boy interrupt controller between the five peripheral interrupt sources and `gb_cpu`. It holds the IF (0xFF0F) and IE (0xFFFF) registers on the CPU bus and edge-detects the peripheral request lines. It drives the CPU's active-low `int_n` while an enabled request is pending. On CPU acknowledge it selects the highest-priority request, clears its IF bit and returns the dispatch vector.

---
 rtl/gb_pkg.sv | 29 ++
 rtl/gb_irq_edge_det.sv | 29 ++
 rtl/gb_int_ctrl.sv | 134 +++++++++++++
 tb/tb_gb_int_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_pkg.sv
// Shared Game Boy constants: register addresses, IRQ bit indices,
// dispatch vector layout and the interrupt controller state encoding.
package gb_pkg;

  localparam logic [15:0] IF_ADDR = 16'hFF0F;
  localparam logic [15:0] IE_ADDR = 16'hFFFF;

  // Interrupt source bit positions; a lower index wins arbitration.
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam logic [15:0] VEC_BASE   = 16'h0040;
  localparam int          VEC_STRIDE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_VEC  = 2'd2
  } int_state_e;

  // Dispatch address for a given source index.
  function automatic logic [15:0] vec_addr(input logic [2:0] idx);
    return VEC_BASE + 16'(idx) * 16'(VEC_STRIDE);
  endfunction

endpackage

// File: rtl/gb_irq_edge_det.sv
// Parameterised rising-edge detector. The history register keeps loading
// the input during reset, so a line held high across reset is not seen
// as a fresh edge once reset is released.
module gb_irq_edge_det #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] hist_q;
  logic [WIDTH-1:0] hist_d;

  // History simply follows the input every cycle.
  always_comb begin
    hist_d = din;
  end

  // History register; reset loads the live input rather than zero.
  always_ff @(posedge clk) begin
    if (rst) hist_q <= din;
    else     hist_q <= hist_d;
  end

  assign rise = din & ~hist_q;

endmodule

// File: rtl/gb_int_ctrl.sv
// Game Boy interrupt controller: IF/IE registers on the CPU bus, edge
// detection of peripheral requests, int_n generation and vector dispatch.
module gb_int_ctrl #(
  parameter int          NUM_IRQ = 5,
  parameter logic [15:0] IF_ADDR = 16'hFF0F,
  parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        addr,
  input  logic [7:0]         data_in,
  input  logic               rd_n,
  input  logic               wr_n,
  output logic [7:0]         data_out,
  output logic               data_oe,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic               int_n,
  input  logic               int_ack,
  output logic [15:0]        vector,
  output logic               vector_valid,
  output logic               wake
);

  import gb_pkg::*;

  int_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic               wr_prev_q, wr_prev_d;
  logic [15:0]        vector_q, vector_d;

  logic               wr_fire, if_wr, ie_wr;
  logic [NUM_IRQ-1:0] edge_set, if_after_wr, pend, pend_ack, ack_clear;
  logic [2:0]         winner;
  logic               dispatch;

  gb_irq_edge_det #(.WIDTH(NUM_IRQ)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (irq_src),
    .rise (edge_set)
  );

  // A write takes effect only on the first edge of a low wr_n strobe.
  assign wr_fire     = !wr_n && wr_prev_q;
  assign if_wr       = wr_fire && (addr == IF_ADDR);
  assign ie_wr       = wr_fire && (addr == IE_ADDR);
  assign wr_prev_d   = wr_n;
  assign if_after_wr = if_wr ? data_in[NUM_IRQ-1:0] : if_q;
  assign ie_d        = ie_wr ? data_in : ie_q;

  // pend drives the request line; pend_ack decides the dispatch and sees a
  // CPU write landing on the acknowledge edge, so that write can cancel it.
  assign pend     = if_q & ie_q[NUM_IRQ-1:0];
  assign pend_ack = if_after_wr & ie_d[NUM_IRQ-1:0];
  assign wake     = |pend;

  // Priority encoder: lowest set index of pend_ack wins.
  always_comb begin
    winner = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend_ack[i]) winner = 3'(i);
    end
  end

  // FSM next state and outputs.
  always_comb begin
    state_d      = state_q;
    vector_d     = vector_q;
    dispatch     = 1'b0;
    int_n        = 1'b1;
    vector_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pend) state_d = ST_REQ;
      end
      ST_REQ: begin
        int_n = 1'b0;
        if (int_ack) begin
          state_d  = ST_VEC;
          dispatch = |pend_ack;
          vector_d = (|pend_ack) ? vec_addr(winner) : 16'h0000;
        end else if (!(|pend)) begin
          state_d = ST_IDLE;
        end
      end
      ST_VEC: begin
        vector_valid = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One-hot clear of the dispatched source.
  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_clr
      assign ack_clear[gi] = dispatch && (winner == 3'(gi));
    end
  endgenerate

  // A new edge beats both the CPU write and the acknowledge clear.
  assign if_d = (if_after_wr & ~ack_clear) | edge_set;

  // Register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      if_q      <= '0;
      ie_q      <= 8'h00;
      wr_prev_q <= 1'b1;
      vector_q  <= 16'h0000;
    end else begin
      state_q   <= state_d;
      if_q      <= if_d;
      ie_q      <= ie_d;
      wr_prev_q <= wr_prev_d;
      vector_q  <= vector_d;
    end
  end

  assign vector  = vector_q;
  assign data_oe = !rd_n && ((addr == IF_ADDR) || (addr == IE_ADDR));

  // Combinational read mux; unused IF bits read as 1.
  always_comb begin
    data_out = 8'hFF;
    if (data_oe) begin
      if (addr == IF_ADDR) data_out = {{(8 - NUM_IRQ){1'b1}}, if_q};
      else                 data_out = ie_q;
    end
  end

endmodule

// File: tb/tb_gb_int_ctrl.sv
// Self-checking bench for gb_int_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_gb_int_ctrl;
  import gb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        rd_n, wr_n;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [4:0]  irq_src;
  logic        int_n;
  logic        int_ack;
  logic [15:0] vector;
  logic        vector_valid;
  logic        wake;

  always #5 clk = ~clk;

  gb_int_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .data_in      (data_in),
    .rd_n         (rd_n),
    .wr_n         (wr_n),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .irq_src      (irq_src),
    .int_n        (int_n),
    .int_ack      (int_ack),
    .vector       (vector),
    .vector_valid (vector_valid),
    .wake         (wake)
  );

  // Reference model state.
  logic [4:0]  m_if, m_prev_src;
  logic [7:0]  m_ie;
  logic        m_prev_wr;
  logic        m_line;    // CPU interrupt line asserted
  logic        m_strobe;  // vector strobe cycle
  logic [15:0] m_vec;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_bit(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Apply the rules of one clock edge to the model.
  task automatic model_edge();
    logic       fire;
    logic [4:0] nif, clr, pr, pa;
    logic [7:0] nie;
    logic       nline, nstrobe;
    int         w;
    if (rst) begin
      m_if = 0; m_ie = 0; m_prev_src = irq_src; m_prev_wr = 1'b1;
      m_line = 0; m_strobe = 0; m_vec = 16'h0000;
    end else begin
      fire = !wr_n && m_prev_wr;
      nif  = (fire && addr == 16'hFF0F) ? data_in[4:0] : m_if;
      nie  = (fire && addr == 16'hFFFF) ? data_in : m_ie;
      pr   = m_if & m_ie[4:0];
      clr  = 0; nline = m_line; nstrobe = 1'b0;
      if (m_strobe) begin
        nline = 1'b0;
      end else if (!m_line) begin
        nline = (pr != 0);
      end else if (int_ack) begin
        pa = nif & nie[4:0];
        w  = lowest_bit(pa);
        if (w >= 0) begin
          clr   = 5'(1 << w);
          m_vec = 16'(64 + 8 * w);
        end else begin
          m_vec = 16'h0000;
        end
        nstrobe = 1'b1;
        nline   = 1'b0;
      end else if (pr == 0) begin
        nline = 1'b0;
      end
      m_if = (nif & ~clr) | (irq_src & ~m_prev_src);
      m_ie = nie;
      m_prev_src = irq_src;
      m_prev_wr  = wr_n;
      m_line = nline;
      m_strobe = nstrobe;
    end
  endtask

  task automatic check_outputs();
    logic       oe;
    logic [7:0] dout;
    oe   = !rd_n && (addr == 16'hFF0F || addr == 16'hFFFF);
    dout = !oe ? 8'hFF : (addr == 16'hFF0F) ? {3'b111, m_if} : m_ie;
    chk("int_n", {15'b0, int_n}, {15'b0, !m_line});
    chk("vector_valid", {15'b0, vector_valid}, {15'b0, m_strobe});
    chk("vector", vector, m_vec);
    chk("wake", {15'b0, wake}, {15'b0, |(m_if & m_ie[4:0])});
    chk("data_oe", {15'b0, data_oe}, {15'b0, oe});
    chk("data_out", {8'b0, data_out}, {8'b0, dout});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; data_in = d; wr_n = 1'b0;
    tick();
    wr_n = 1'b1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 8 && int_n !== 1'b0; i++) tick();
    chk("wait_req", {15'b0, int_n}, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; addr = 16'h0000; data_in = 8'h00; rd_n = 1'b1; wr_n = 1'b1;
    irq_src = 5'b00001; int_ack = 1'b0;
    m_if = 0; m_ie = 0; m_prev_src = 0; m_prev_wr = 1; m_line = 0; m_strobe = 0; m_vec = 0;

    // Source held high through reset must not raise a flag.
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    rd_n = 1'b0; addr = IF_ADDR; #1;
    chk("reset_if_read", {8'b0, data_out}, 16'h00E0);
    chk("reset_int_n", {15'b0, int_n}, 16'h0001);
    chk("reset_vector", vector, 16'h0000);
    rd_n = 1'b1;

    // Timer pulse and dispatch.
    irq_src = 5'b00000;
    bus_write(IE_ADDR, 8'h1F);
    irq_src[IRQ_TIMER] = 1'b1;
    tick();
    chk("timer_int_n_k", {15'b0, int_n}, 16'h0001);
    irq_src = 5'b00000;
    tick();
    chk("timer_int_n_k1", {15'b0, int_n}, 16'h0000);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("timer_vector", vector, 16'h0050);
    chk("timer_vv", {15'b0, vector_valid}, 16'h0001);
    chk("timer_wake", {15'b0, wake}, 16'h0000);
    tick();
    chk("timer_vv_end", {15'b0, vector_valid}, 16'h0000);

    // Two sources set together: STAT first, then JOYPAD.
    bus_write(IF_ADDR, 8'h12);
    wait_req();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("stat_vector", vector, 16'h0048);
    wait_req();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("joypad_vector", vector, 16'h0060);
    rd_n = 1'b0; addr = IF_ADDR; tick(); rd_n = 1'b1;
    chk("two_src_if_clear", {8'b0, data_out}, 16'h00E0);

    // CPU clears IF while in REQ: request withdrawn, later ack ignored.
    bus_write(IF_ADDR, 8'h04);
    wait_req();
    bus_write(IF_ADDR, 8'h00);
    tick();
    chk("withdraw_int_n", {15'b0, int_n}, 16'h0001);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("withdraw_ack_ignored", {15'b0, vector_valid}, 16'h0000);
    tick();

    // IE cleared on the acknowledge edge: cancelled dispatch.
    bus_write(IF_ADDR, 8'h01);
    wait_req();
    addr = IE_ADDR; data_in = 8'h00; wr_n = 1'b0; int_ack = 1'b1;
    tick();
    wr_n = 1'b1; int_ack = 1'b0;
    chk("cancel_vector", vector, 16'h0000);
    chk("cancel_vv", {15'b0, vector_valid}, 16'h0001);
    rd_n = 1'b0; addr = IF_ADDR; tick(); rd_n = 1'b1;
    chk("cancel_if_kept", {8'b0, data_out}, 16'h00E1);

    // Edge beats a same-edge write of zero.
    addr = IF_ADDR; data_in = 8'h00; wr_n = 1'b0; irq_src[IRQ_VBLANK] = 1'b1;
    tick();
    wr_n = 1'b1;
    rd_n = 1'b0; addr = IF_ADDR; #1;
    chk("edge_wins_read", {8'b0, data_out}, 16'h00E1);
    chk("edge_wins_oe", {15'b0, data_oe}, 16'h0001);
    addr = 16'hFF10; #1;
    chk("miss_oe", {15'b0, data_oe}, 16'h0000);
    rd_n = 1'b1;
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [1:0] sel;
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) irq_src = 5'($urandom);
      if (!wr_n) wr_n = $urandom_range(0, 1) == 0;
      else if ($urandom_range(0, 7) == 0) wr_n = 1'b0;
      sel = 2'($urandom_range(0, 3));
      case (sel)
        2'd0: addr = IF_ADDR;
        2'd1: addr = IE_ADDR;
        2'd2: addr = 16'hFF10;
        default: addr = 16'hC000;
      endcase
      data_in = 8'($urandom);
      rd_n    = $urandom_range(0, 1) == 0;
      int_ack = $urandom_range(0, 2) == 0;
      tick();
    end
    rst = 1'b0; int_ack = 1'b0; wr_n = 1'b1; rd_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
